// File: rtl/baser_pkg.sv
// Shared BASE-R definitions: sync-header codes, lock FSM states, MII/BASE-R
// characters used by the downstream checker, and small elaboration helpers.
package baser_pkg;

    // 66b sync headers; 2'b00 and 2'b11 never occur on a correctly aligned link
    localparam logic [1:0] SH_CTRL = 2'b01;
    localparam logic [1:0] SH_DATA = 2'b10;

    typedef enum logic [1:0] {
        TEST      = 2'd0,
        SLIP      = 2'd1,
        SLIP_WAIT = 2'd2,
        LOCKED    = 2'd3
    } lock_state_t;

    // MII control characters
    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERROR = 8'hFE;

    // BASE-R 7-bit control codes and common block type fields
    localparam logic [6:0] BR_IDLE   = 7'h00;
    localparam logic [6:0] BR_ERROR  = 7'h1E;
    localparam logic [7:0] BT_C8     = 8'h1E;
    localparam logic [7:0] BT_S0     = 8'h78;
    localparam logic [7:0] BT_T0     = 8'h87;

    // True for the two legal sync-header codes
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_CTRL) || (sh == SH_DATA);
    endfunction

    // Width of a counter that must hold 0..max; never narrower than 1 bit
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/baser_hi_ber_mon.sv
// High bit-error-rate monitor: counts invalid sync headers over a window of
// BER_WIN valid blocks while lock is held. Only built with BASER_HI_BER_EN,
// since the lock controller instantiates it only in that configuration.
`ifdef BASER_HI_BER_EN
module baser_hi_ber_mon #(
    parameter int BER_WIN    = 2048,
    parameter int BER_THRESH = 97
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_valid,
    input  logic i_sh_inv,
    input  logic i_lock,
    output logic o_hi_ber
);
    import baser_pkg::*;

    localparam int BW_W = cnt_w(BER_WIN);
    localparam int BC_W = cnt_w(BER_THRESH);
    localparam logic [BW_W-1:0] WIN_LAST = BW_W'(BER_WIN - 1);
    localparam logic [BC_W-1:0] CNT_MAX  = BC_W'(BER_THRESH);

    logic [BW_W-1:0] win_q;
    logic [BC_W-1:0] cnt_q;
    logic [BC_W-1:0] cnt_nxt;
    logic            hi_q;

    // Saturating increment so the count never passes the threshold
    function automatic logic [BC_W-1:0] sat_inc(input logic [BC_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    // Error count including the current block
    always_comb begin
        cnt_nxt = sat_inc(cnt_q, i_sh_inv);
    end

    // Window/count registers; the flag is re-evaluated at every window end
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            win_q <= '0;
            cnt_q <= '0;
            hi_q  <= 1'b0;
        end else if (!i_lock) begin
            win_q <= '0;
            cnt_q <= '0;
            hi_q  <= 1'b0;
        end else if (i_valid) begin
            if (win_q == WIN_LAST) begin
                win_q <= '0;
                cnt_q <= '0;
                hi_q  <= (cnt_nxt == CNT_MAX);
            end else begin
                win_q <= win_q + 1'b1;
                cnt_q <= cnt_nxt;
                if (cnt_nxt == CNT_MAX) begin
                    hi_q <= 1'b1;
                end
            end
        end
    end

    assign o_hi_ber = hi_q;

endmodule
`endif

// File: rtl/baser_block_lock_ctrl.sv
// 64B/66B BASE-R block-lock controller. Hunts for 66b boundaries by checking
// sync headers and requesting slips, forwards blocks only while locked, and
// keeps slip / lock-loss statistics. Optional hi-BER monitor: BASER_HI_BER_EN.
module baser_block_lock_ctrl #(
    parameter int FRAME_WIDTH = 66,
    parameter int LOCK_CNT    = 64,
    parameter int WIN_CNT     = 64,
    parameter int INV_MAX     = 16,
    parameter int SLIP_WAIT   = 4
`ifdef BASER_HI_BER_EN
    ,
    parameter int BER_WIN     = 2048,
    parameter int BER_THRESH  = 97
`endif
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [FRAME_WIDTH-1:0] i_rx_coded,
    output logic                   o_valid,
    output logic [FRAME_WIDTH-1:0] o_rx_coded,
    output logic                   o_slip,
    output logic                   o_block_lock,
    output logic                   o_hi_ber,
    output logic [31:0]            o_slip_count,
    output logic [31:0]            o_lock_loss_count
);
    import baser_pkg::*;

    localparam int SH_W  = cnt_w(LOCK_CNT);
    localparam int WIN_W = cnt_w(WIN_CNT);
    localparam int INV_W = cnt_w(INV_MAX);
    localparam int WT_W  = cnt_w(SLIP_WAIT);
    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CNT - 1);
    localparam logic [INV_W-1:0] INV_LAST = INV_W'(INV_MAX - 1);
    localparam logic [WT_W-1:0]  WT_LAST  = WT_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

    lock_state_t      state_q, state_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
    logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             lock_q, lock_d;
    logic             slip_d;
    logic             loss_d;
    logic             hdr_inv;

    logic                   valid_p1;
    logic [FRAME_WIDTH-1:0] rx_coded_p1;
    logic                   slip_p1;
    logic [31:0]            slip_count_q;
    logic [31:0]            lock_loss_count_q;
    logic                   hi_ber;

    assign hdr_inv = !sh_is_valid(i_rx_coded[1:0]);

    // Lock FSM state register; counters and flags move with it
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= TEST;
            sh_cnt_q   <= '0;
            win_cnt_q  <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            win_cnt_q  <= win_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            lock_q     <= lock_d;
        end
    end

    // Next-state logic; everything holds on cycles without a block
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        win_cnt_d  = win_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        loss_d     = 1'b0;
        if (i_valid) begin
            case (state_q)
                TEST: begin
                    if (hdr_inv) begin
                        state_d = SLIP;
                    end else if (sh_cnt_q == SH_LAST) begin
                        state_d   = LOCKED;
                        lock_d    = 1'b1;
                        sh_cnt_d  = '0;
                        win_cnt_d = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + 1'b1;
                    end
                end
                SLIP: begin
                    // the block seen here is discarded; the aligner shifts next
                    slip_d     = 1'b1;
                    sh_cnt_d   = '0;
                    win_cnt_d  = '0;
                    inv_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = (SLIP_WAIT > 0) ? baser_pkg::SLIP_WAIT : TEST;
                end
                baser_pkg::SLIP_WAIT: begin
                    if (wait_cnt_q == WT_LAST) begin
                        wait_cnt_d = '0;
                        state_d    = TEST;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // threshold is tested before window end so it wins a tie
                    if (hdr_inv && (inv_cnt_q == INV_LAST)) begin
                        state_d   = SLIP;
                        lock_d    = 1'b0;
                        loss_d    = 1'b1;
                        win_cnt_d = '0;
                        inv_cnt_d = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        inv_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        if (hdr_inv) begin
                            inv_cnt_d = inv_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = TEST;
                end
            endcase
        end
    end

    // Output stage: one cycle behind the input, gated by pre-transition state
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            valid_p1          <= 1'b0;
            rx_coded_p1       <= '0;
            slip_p1           <= 1'b0;
            slip_count_q      <= '0;
            lock_loss_count_q <= '0;
        end else begin
            valid_p1 <= i_valid && (state_q == LOCKED);
            slip_p1  <= slip_d;
            if (i_valid) begin
                rx_coded_p1 <= i_rx_coded;
            end
            if (slip_d) begin
                slip_count_q <= slip_count_q + 32'd1;
            end
            if (loss_d) begin
                lock_loss_count_q <= lock_loss_count_q + 32'd1;
            end
        end
    end

`ifdef BASER_HI_BER_EN
    // Monitor sees lock drop in the same cycle the lock-losing block arrives,
    // so its flag clears together with o_block_lock
    logic ber_lock;
    assign ber_lock = lock_q && lock_d;

    baser_hi_ber_mon #(
        .BER_WIN    (BER_WIN),
        .BER_THRESH (BER_THRESH)
    ) u_hi_ber_mon (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_sh_inv (hdr_inv),
        .i_lock   (ber_lock),
        .o_hi_ber (hi_ber)
    );
`else
    assign hi_ber = 1'b0;
`endif

    assign o_valid           = valid_p1;
    assign o_rx_coded        = rx_coded_p1;
    assign o_slip            = slip_p1;
    assign o_block_lock      = lock_q;
    assign o_hi_ber          = hi_ber;
    assign o_slip_count      = slip_count_q;
    assign o_lock_loss_count = lock_loss_count_q;

endmodule

// File: tb/tb_baser_block_lock_ctrl.sv
// Randomized self-checking bench for baser_block_lock_ctrl with a behavioural
// lock model. Hi-BER checks follow BASER_HI_BER_EN.
module tb_baser_block_lock_ctrl;

    localparam int FW         = 66;
    localparam int LOCK_CNT   = 64;
    localparam int WIN_CNT    = 64;
    localparam int INV_MAX    = 16;
    localparam int SLIP_WAIT  = 4;
    localparam int BER_WIN    = 256;
    localparam int BER_THRESH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [FW-1:0] data;
    logic          o_valid;
    logic [FW-1:0] o_rx_coded;
    logic          o_slip;
    logic          o_block_lock;
    logic          o_hi_ber;
    logic [31:0]   o_slip_count;
    logic [31:0]   o_lock_loss_count;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model
    bit          m_locked, m_pend, m_hi;
    int          m_good, m_settle, m_win, m_bad, ber_win, ber_bad;
    logic [31:0] m_slips, m_losses;
    logic [FW-1:0] m_data;
    bit          e_valid, e_slip;

    always #5 clk = ~clk;

    baser_block_lock_ctrl #(
        .FRAME_WIDTH (FW),
        .LOCK_CNT    (LOCK_CNT),
        .WIN_CNT     (WIN_CNT),
        .INV_MAX     (INV_MAX),
        .SLIP_WAIT   (SLIP_WAIT)
`ifdef BASER_HI_BER_EN
        ,
        .BER_WIN     (BER_WIN),
        .BER_THRESH  (BER_THRESH)
`endif
    ) dut (
        .clk               (clk),
        .i_rst             (rst),
        .i_valid           (valid),
        .i_rx_coded        (data),
        .o_valid           (o_valid),
        .o_rx_coded        (o_rx_coded),
        .o_slip            (o_slip),
        .o_block_lock      (o_block_lock),
        .o_hi_ber          (o_hi_ber),
        .o_slip_count      (o_slip_count),
        .o_lock_loss_count (o_lock_loss_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_pend = 0; m_hi = 0;
        m_good = 0; m_settle = 0; m_win = 0; m_bad = 0; ber_win = 0; ber_bad = 0;
        m_slips = '0; m_losses = '0; m_data = '0;
        e_valid = 0; e_slip = 0;
    endtask

    // One received block (or idle cycle) applied to the abstract lock rules
    task automatic model_step(input bit v, input bit bad, input logic [FW-1:0] d);
        bit was_locked;
        bit lost;
        e_valid = 0;
        e_slip  = 0;
        if (!v) return;
        m_data     = d;
        was_locked = m_locked;
        lost       = 0;
        e_valid    = m_locked;
        if (m_pend) begin
            e_slip   = 1;
            m_slips  = m_slips + 1;
            m_pend   = 0;
            m_settle = SLIP_WAIT;
            m_good   = 0;
        end else if (m_settle > 0) begin
            m_settle--;
        end else if (!m_locked) begin
            if (bad) begin
                m_pend = 1;
                m_good = 0;
            end else begin
                m_good++;
                if (m_good == LOCK_CNT) begin
                    m_locked = 1; m_good = 0; m_win = 0; m_bad = 0;
                end
            end
        end else begin
            m_win++;
            if (bad) m_bad++;
            if (m_bad == INV_MAX) begin
                m_locked = 0; lost = 1; m_losses = m_losses + 1; m_pend = 1;
                m_win = 0; m_bad = 0;
            end else if (m_win == WIN_CNT) begin
                m_win = 0; m_bad = 0;
            end
        end
`ifdef BASER_HI_BER_EN
        if (was_locked && !lost) begin
            ber_win++;
            if (bad && ber_bad < BER_THRESH) ber_bad++;
            if (ber_win == BER_WIN) begin
                m_hi = (ber_bad == BER_THRESH);
                ber_win = 0; ber_bad = 0;
            end else if (ber_bad == BER_THRESH) begin
                m_hi = 1;
            end
        end else if (lost) begin
            ber_win = 0; ber_bad = 0; m_hi = 0;
        end
`else
        if (was_locked && lost) m_hi = 0;
`endif
    endtask

    task automatic compare_all();
        check("o_valid", o_valid, e_valid);
        check("o_slip", o_slip, e_slip);
        check("o_block_lock", o_block_lock, m_locked);
        check("o_hi_ber", o_hi_ber, m_hi);
        check("o_slip_count", o_slip_count, m_slips);
        check("o_lock_loss_count", o_lock_loss_count, m_losses);
        check("o_rx_coded", o_rx_coded, m_data);
    endtask

    task automatic apply(input bit v, input bit bad);
        logic [1:0]    hdr;
        logic [FW-1:0] d;
        @(negedge clk);
        if (bad) hdr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        else     hdr = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        d     = {$urandom(), $urandom(), hdr};
        valid = v;
        data  = d;
        model_step(v, bad, d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Clean blocks with random gaps until the model reports lock (bounded)
    task automatic acquire(input int gap_pct);
        for (int i = 0; i < 600 && !m_locked; i++) begin
            apply($urandom_range(0, 99) >= gap_pct, 1'b0);
        end
        check("acquire_lock", o_block_lock, 1'b1);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once
    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit mask [64];
        int k;
        int p;
        int rate;
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // clean acquisition, then first forwarded block
        acquire(0);
        check("no_slip_on_clean_lock", o_slip_count, 32'd0);
        apply(1'b1, 1'b0);
        check("first_forwarded", o_valid, 1'b1);

        // 16 invalid headers inside one window drop lock
        for (int i = 0; i < 24; i++) apply(1'b1, i < 16);
        check("loss_after_16_bad", o_lock_loss_count, 32'd1);

        // invalid header at block 10 of the hunt
        do_reset();
        for (int i = 0; i < 10; i++) apply(1'b1, i == 9);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0);
        check("slip_at_block10", o_slip_count, 32'd1);
        acquire(0);

        // 15 invalid per window is tolerated; the 16th as window end is not
        for (int w = 0; w < 11; w++) begin
            for (int i = 0; i < 64; i++) mask[i] = 0;
            k = 0;
            while (k < 15) begin
                p = $urandom_range(0, (w == 10) ? 62 : 63);
                if (!mask[p]) begin
                    mask[p] = 1;
                    k++;
                end
            end
            if (w == 10) mask[63] = 1;
            for (int i = 0; i < 64; i++) apply(1'b1, mask[i]);
        end

        // acquisition with i_valid gaps
        do_reset();
        acquire(50);

        // random traffic with changing error rates and gaps
        for (int c = 0; c < 8; c++) begin
            rate = (c % 3 == 0) ? 0 : ((c % 3 == 1) ? 3 : 25);
            for (int i = 0; i < 200; i++)
                apply($urandom_range(0, 99) < 80, $urandom_range(0, 99) < rate);
        end

        // sparse errors under lock, then clean windows, then reset mid-run
        do_reset();
        acquire(0);
        for (int i = 0; i < 1024; i++)
            apply(1'b1, ($urandom_range(0, 99) < 4) && (m_bad < 10));
        for (int i = 0; i < 600; i++) apply($urandom_range(0, 99) < 90, 1'b0);
        for (int i = 0; i < 100; i++)
            apply(1'b1, ($urandom_range(0, 99) < 10) && (m_bad < 10));
        do_reset();
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
